// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: line geometry and the aligner state encoding.
package ifu_pkg;
  localparam int unsigned IFU_ADDR_WIDTH = 48;
  localparam int unsigned IFU_DATA_WIDTH = 128;
  localparam int unsigned HW_PER_LINE    = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    ACTIVE   = 2'b01,
    STRADDLE = 2'b10
  } ifu_state_e;
endpackage

// File: rtl/ifu_instr_align.sv
// Splits 128-bit fetch lines into RV32/RVC instructions, stitching 32-bit
// instructions that straddle two consecutive lines.
module ifu_instr_align #(
  parameter int unsigned IFU_ADDR_WIDTH = ifu_pkg::IFU_ADDR_WIDTH,
  parameter int unsigned IFU_DATA_WIDTH = ifu_pkg::IFU_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_valid,
  output logic                      line_ready,
  input  logic [IFU_DATA_WIDTH-1:0] line_data,
  input  logic [IFU_ADDR_WIDTH-1:0] line_addr,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [IFU_ADDR_WIDTH+3:0] instr_pc,
  output logic                      instr_rvc,
  input  logic                      flush,
  input  logic [2:0]                flush_hw_off
);
  import ifu_pkg::*;

  localparam int unsigned PC_W = IFU_ADDR_WIDTH + 4;

  ifu_state_e                r_state,      w_state_nxt;
  logic [IFU_DATA_WIDTH-1:0] r_line_q,     w_line_nxt;
  logic [IFU_ADDR_WIDTH-1:0] r_addr_q,     w_addr_nxt;
  logic [2:0]                r_hw_ptr,     w_hw_ptr_nxt;
  logic [15:0]               r_carry_q,    w_carry_nxt;
  logic [PC_W-1:0]           r_carry_pc_q, w_carry_pc_nxt;
  logic                      r_strad_pend, w_strad_nxt;
  logic [2:0]                r_start_off,  w_start_off_nxt;

  logic [2:0]  w_ptr_p1;
  logic [15:0] w_hw_lo;
  logic [15:0] w_hw_hi;
  logic        w_is32;
  logic        w_detect;
  logic        w_line_fire;
  logic        w_instr_fire;
  logic [3:0]  w_adv;

  assign w_ptr_p1 = r_hw_ptr + 3'd1;
  assign w_hw_lo  = r_line_q[{r_hw_ptr, 4'b0000} +: 16];
  assign w_hw_hi  = r_line_q[{w_ptr_p1, 4'b0000} +: 16];
  assign w_is32   = (w_hw_lo[1:0] == 2'b11);
  assign w_adv    = {1'b0, r_hw_ptr} + (w_is32 ? 4'd2 : 4'd1);

  // A 32-bit instruction in the last halfword cannot be presented yet; its
  // low half is parked in carry while the next line is fetched.
  assign w_detect = (r_state == ACTIVE) && !r_strad_pend && w_is32 &&
                    (r_hw_ptr == 3'(HW_PER_LINE - 1));

  assign line_ready   = !flush && ((r_state == EMPTY) || (r_state == STRADDLE));
  assign instr_valid  = !flush && (r_state == ACTIVE) && !w_detect;
  assign w_line_fire  = line_valid && line_ready;
  assign w_instr_fire = instr_valid && instr_ready;

  always_comb begin
    instr     = '0;
    instr_pc  = '0;
    instr_rvc = 1'b0;
    if (instr_valid) begin
      if (r_strad_pend) begin
        instr    = {r_line_q[15:0], r_carry_q};
        instr_pc = r_carry_pc_q;
      end else begin
        instr     = w_is32 ? {w_hw_hi, w_hw_lo} : {16'h0000, w_hw_lo};
        instr_pc  = {r_addr_q, r_hw_ptr, 1'b0};
        instr_rvc = !w_is32;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_line_nxt      = r_line_q;
    w_addr_nxt      = r_addr_q;
    w_hw_ptr_nxt    = r_hw_ptr;
    w_carry_nxt     = r_carry_q;
    w_carry_pc_nxt  = r_carry_pc_q;
    w_strad_nxt     = r_strad_pend;
    w_start_off_nxt = r_start_off;
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_strad_nxt     = 1'b0;
      w_carry_nxt     = '0;
      w_carry_pc_nxt  = '0;
      w_start_off_nxt = flush_hw_off;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_line_fire) begin
            w_line_nxt      = line_data;
            w_addr_nxt      = line_addr;
            w_hw_ptr_nxt    = r_start_off;
            w_start_off_nxt = '0;
            w_state_nxt     = ACTIVE;
          end
        end
        ACTIVE: begin
          if (r_strad_pend) begin
            if (w_instr_fire) begin
              w_strad_nxt  = 1'b0;
              w_hw_ptr_nxt = 3'd1;
            end
          end else if (w_detect) begin
            w_carry_nxt    = w_hw_lo;
            w_carry_pc_nxt = {r_addr_q, 3'd7, 1'b0};
            w_state_nxt    = STRADDLE;
          end else if (w_instr_fire) begin
            w_hw_ptr_nxt = w_adv[2:0];
            if (w_adv[3]) w_state_nxt = EMPTY;
          end
        end
        STRADDLE: begin
          if (w_line_fire) begin
            w_line_nxt   = line_data;
            w_addr_nxt   = line_addr;
            w_hw_ptr_nxt = '0;
            w_strad_nxt  = 1'b1;
            w_state_nxt  = ACTIVE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_line_q     <= '0;
      r_addr_q     <= '0;
      r_hw_ptr     <= '0;
      r_carry_q    <= '0;
      r_carry_pc_q <= '0;
      r_strad_pend <= 1'b0;
      r_start_off  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_line_q     <= w_line_nxt;
      r_addr_q     <= w_addr_nxt;
      r_hw_ptr     <= w_hw_ptr_nxt;
      r_carry_q    <= w_carry_nxt;
      r_carry_pc_q <= w_carry_pc_nxt;
      r_strad_pend <= w_strad_nxt;
      r_start_off  <= w_start_off_nxt;
    end
  end
endmodule

// File: tb/tb_ifu_instr_align.sv
// Bench for ifu_instr_align: directed scenarios plus a randomized run checked
// against a halfword-stream reference model.
module tb_ifu_instr_align;
  localparam int AW = 48;
  localparam int PW = 52;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_valid = 1'b0;
  logic          line_ready;
  logic [127:0]  line_data = '0;
  logic [AW-1:0] line_addr = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [PW-1:0] instr_pc;
  logic          instr_rvc;
  logic          flush = 1'b0;
  logic [2:0]    flush_hw_off = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ifu_instr_align #(.IFU_ADDR_WIDTH(AW), .IFU_DATA_WIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_valid(line_valid), .line_ready(line_ready),
    .line_data(line_data), .line_addr(line_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_rvc(instr_rvc),
    .flush(flush), .flush_hw_off(flush_hw_off)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input logic [AW-1:0] a, input logic [127:0] d, output bit ok);
    ok = 1'b0;
    line_addr = a;
    line_data = d;
    line_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (line_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    line_valid = 1'b0;
  endtask

  task automatic get_instr(output bit ok, output logic [31:0] i, output logic [PW-1:0] pc,
                           output logic rvc);
    ok = 1'b0;
    i = '0;
    pc = '0;
    rvc = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (instr_valid) begin
        ok = 1'b1;
        i = instr;
        pc = instr_pc;
        rvc = instr_rvc;
      end
      tick();
      if (ok) break;
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (line_ready !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 ||
        instr_pc !== '0 || instr_rvc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got lr=%b iv=%b instr=%h pc=%h rvc=%b, want lr=1 iv=0 instr=0 pc=0 rvc=0",
               line_ready, instr_valid, instr, instr_pc, instr_rvc);
    end
    tick();
  endtask

  task automatic test_four32();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    send_line(48'h0, {4{32'h00000013}}, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL four32_accept: got no line fire, want fire"); end
    for (int k = 0; k < 4; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== 32'h00000013 || pc !== PW'(4 * k) || r !== 1'b0) begin
        n_bad++;
        $display("FAIL four32[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00000013 pc=%h rvc=0",
                 k, ok, i, pc, r, PW'(4 * k));
      end
    end
    #1;
    n_cmp++;
    if (line_ready !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL four32_end: got lr=%b iv=%b, want lr=1 iv=0", line_ready, instr_valid);
    end
    tick();
  endtask

  task automatic test_rvc8();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    send_line(48'h0, {8{16'h0001}}, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rvc8_accept: got no line fire, want fire"); end
    for (int k = 0; k < 8; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== 32'h00000001 || pc !== PW'(2 * k) || r !== 1'b1) begin
        n_bad++;
        $display("FAIL rvc8[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00000001 pc=%h rvc=1",
                 k, ok, i, pc, r, PW'(2 * k));
      end
    end
  endtask

  task automatic test_straddle();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    send_line(48'h5, {16'h0513, {7{16'h4501}}}, ok);
    for (int k = 0; k < 7; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== 32'h00004501 || pc !== PW'(32'h50 + 2 * k) || r !== 1'b1) begin
        n_bad++;
        $display("FAIL straddle_pre[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00004501 pc=%h rvc=1",
                 k, ok, i, pc, r, PW'(32'h50 + 2 * k));
      end
    end
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || line_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL straddle_detect: got iv=%b lr=%b, want iv=0 lr=0", instr_valid, line_ready);
    end
    tick();
    send_line(48'h6, {{7{16'h0001}}, 16'h00A0}, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL straddle_accept: got no line fire, want fire"); end
    get_instr(ok, i, pc, r);
    n_cmp++;
    if (!ok || i !== 32'h00A00513 || pc !== PW'(32'h5E) || r !== 1'b0) begin
      n_bad++;
      $display("FAIL straddle_join: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00a00513 pc=5e rvc=0",
               ok, i, pc, r);
    end
    for (int k = 0; k < 7; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== 32'h00000001 || pc !== PW'(32'h62 + 2 * k) || r !== 1'b1) begin
        n_bad++;
        $display("FAIL straddle_post[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00000001 pc=%h rvc=1",
                 k, ok, i, pc, r, PW'(32'h62 + 2 * k));
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    logic [127:0] d;
    send_line(48'h20, {8{16'h0001}}, ok);
    get_instr(ok, i, pc, r);
    get_instr(ok, i, pc, r);
    flush = 1'b1;
    flush_hw_off = 3'd3;
    instr_ready = 1'b1;
    line_valid = 1'b1;
    line_addr = 48'h77;
    line_data = {8{16'h0005}};
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || line_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_mask: got iv=%b lr=%b, want iv=0 lr=0", instr_valid, line_ready);
    end
    tick();
    flush = 1'b0;
    instr_ready = 1'b0;
    line_valid = 1'b0;
    for (int k = 0; k < 8; k++) d[16*k +: 16] = 16'h1000 | 16'(k << 2);
    send_line(48'h10, d, ok);
    for (int k = 0; k < 5; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== {16'h0, 16'h1000 | 16'((k + 3) << 2)} || pc !== PW'(32'h106 + 2 * k) || r !== 1'b1) begin
        n_bad++;
        $display("FAIL flush_resume[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=%h pc=%h rvc=1",
                 k, ok, i, pc, r, {16'h0, 16'h1000 | 16'((k + 3) << 2)}, PW'(32'h106 + 2 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    send_line(48'h30, {{5{16'h0001}}, 16'h00A0, 16'h0513, 16'h4501}, ok);
    get_instr(ok, i, pc, r);
    n_cmp++;
    if (!ok || i !== 32'h00004501 || pc !== PW'(32'h300) || r !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00004501 pc=300 rvc=1",
               ok, i, pc, r);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A00513 || instr_pc !== PW'(32'h302) ||
          instr_rvc !== 1'b0 || line_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got iv=%b instr=%h pc=%h rvc=%b lr=%b, want iv=1 instr=00a00513 pc=302 rvc=0 lr=0",
                 c, instr_valid, instr, instr_pc, instr_rvc, line_ready);
      end
      tick();
    end
    get_instr(ok, i, pc, r);
    n_cmp++;
    if (!ok || i !== 32'h00A00513 || pc !== PW'(32'h302) || r !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00a00513 pc=302 rvc=0",
               ok, i, pc, r);
    end
    for (int k = 0; k < 5; k++) begin
      get_instr(ok, i, pc, r);
      n_cmp++;
      if (!ok || i !== 32'h00000001 || pc !== PW'(32'h306 + 2 * k) || r !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_tail[%0d]: got ok=%0b instr=%h pc=%h rvc=%b, want instr=00000001 pc=%h rvc=1",
                 k, ok, i, pc, r, PW'(32'h306 + 2 * k));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] i;
    logic [PW-1:0] pc;
    logic r;
    // Reset while an instruction is being presented, between clock edges.
    send_line(48'h40, {8{16'h0001}}, ok);
    get_instr(ok, i, pc, r);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== '0 || instr_rvc !== 1'b0 ||
        line_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_active: got iv=%b instr=%h pc=%h rvc=%b lr=%b, want iv=0 instr=0 pc=0 rvc=0 lr=1",
               instr_valid, instr, instr_pc, instr_rvc, line_ready);
    end
    rst_n = 1'b1;
    tick();
    send_line(48'h5, {16'h0513, {7{16'h4501}}}, ok);
    for (int k = 0; k < 7; k++) get_instr(ok, i, pc, r);
    tick();
    #1;
    n_cmp++;
    if (line_ready !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_straddle_state: got lr=%b iv=%b, want lr=1 iv=0", line_ready, instr_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== '0 || instr_rvc !== 1'b0 ||
        line_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_straddle: got iv=%b instr=%h pc=%h rvc=%b lr=%b, want iv=0 instr=0 pc=0 rvc=0 lr=1",
               instr_valid, instr, instr_pc, instr_rvc, line_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_line(48'h6, {{7{16'h0001}}, 16'h00A0}, ok);
    get_instr(ok, i, pc, r);
    n_cmp++;
    if (!ok || i !== 32'h000000A0 || pc !== PW'(32'h60) || r !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_no_carry: got ok=%0b instr=%h pc=%h rvc=%b, want instr=000000a0 pc=60 rvc=1",
               ok, i, pc, r);
    end
    for (int k = 0; k < 7; k++) get_instr(ok, i, pc, r);
  endtask

  // Reference: the accepted lines form a halfword stream tagged with byte PCs;
  // each fired instruction consumes one or two halfwords from its head.
  task automatic test_random();
    logic [15:0]   hq[$];
    logic [PW-1:0] pq[$];
    logic [2:0]    next_off;
    logic [AW-1:0] na;
    logic [127:0]  ld;
    logic [15:0]   h;
    logic [15:0]   hw;
    logic [PW-1:0] p;
    logic [31:0]   e;
    logic          er;
    bit            have_line;
    bit            f;
    bit            lf;
    bit            ifr;
    bit            drain;
    next_off = '0;
    have_line = 1'b0;
    ld = '0;
    flush = 1'b1;
    flush_hw_off = 3'd0;
    tick();
    flush = 1'b0;
    na = {$urandom, $urandom} >> 16;
    for (int cyc = 0; cyc < 3030; cyc++) begin
      drain = (cyc >= 3000);
      if (!have_line) begin
        for (int k = 0; k < 8; k++) begin
          hw = 16'($urandom);
          if ($urandom % 5 < 2) hw[1:0] = 2'b11;
          else hw[1:0] = 2'($urandom % 3);
          ld[16*k +: 16] = hw;
        end
        have_line = 1'b1;
      end
      f = !drain && ($urandom % 40 == 0);
      line_valid = !drain && ($urandom % 4 != 0);
      line_addr = na;
      line_data = ld;
      instr_ready = drain || ($urandom % 4 != 0);
      flush = f;
      flush_hw_off = 3'($urandom);
      #1;
      if (f) begin
        n_cmp++;
        if (line_ready !== 1'b0 || instr_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_flush_mask: got lr=%b iv=%b, want lr=0 iv=0", line_ready, instr_valid);
        end
      end
      lf = line_valid && line_ready;
      ifr = instr_valid && instr_ready;
      if (ifr) begin
        n_cmp++;
        if (hq.size() == 0) begin
          n_bad++;
          $display("FAIL rand_instr: got instr=%h pc=%h with no halfwords outstanding, want no instruction",
                   instr, instr_pc);
        end else begin
          h = hq.pop_front();
          p = pq.pop_front();
          if (h[1:0] == 2'b11) begin
            if (hq.size() == 0) begin
              e = {16'hxxxx, h};
            end else begin
              e = {hq.pop_front(), h};
              void'(pq.pop_front());
            end
            er = 1'b0;
          end else begin
            e = {16'h0, h};
            er = 1'b1;
          end
          if (instr !== e || instr_pc !== p || instr_rvc !== er) begin
            n_bad++;
            $display("FAIL rand_instr[%0d]: got instr=%h pc=%h rvc=%b, want instr=%h pc=%h rvc=%b",
                     cyc, instr, instr_pc, instr_rvc, e, p, er);
          end
        end
      end
      if (lf) begin
        for (int k = int'(next_off); k < 8; k++) begin
          hq.push_back(ld[16*k +: 16]);
          pq.push_back({na, 3'(k), 1'b0});
        end
        next_off = '0;
        na = na + 1'b1;
        have_line = 1'b0;
      end
      if (f) begin
        hq.delete();
        pq.delete();
        next_off = flush_hw_off;
        na = {$urandom, $urandom} >> 16;
        have_line = 1'b0;
      end
      tick();
    end
    line_valid = 1'b0;
    instr_ready = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (!(hq.size() == 0 || (hq.size() == 1 && hq[0][1:0] == 2'b11))) begin
      n_bad++;
      $display("FAIL rand_drain: got %0d halfwords left unconsumed, want 0 (or one straddle half)",
               hq.size());
    end
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_four32();
    test_rvc8();
    test_straddle();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
